// File: rtl/fp_round_stage.sv
`default_nettype none
// =============================================================================
// Module   : fp_round_stage
// Purpose  : Two-stage valid/ready IEEE-754 rounding and saturation stage that
//            turns an unrounded arithmetic result into a final encoding + fflags.
// Options  : FP_ROUND_FLAGS_ACC_EN adds flags_clr_i / flags_acc_o (sticky fflags).
// Revision : 1.0 - initial release
// =============================================================================

package fp_round_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP64 = 2'd1,
        FP16 = 2'd2,
        BF16 = 2'd3
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP64:    return 64;
            FP16:    return 16;
            BF16:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            BF16:    return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            BF16:    return 7;
            default: return 23;
        endcase
    endfunction

endpackage

module fp_round_stage
    import fp_round_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32,
    localparam int unsigned FP_WIDTH   = fp_width(FP_FORMAT),
    localparam int unsigned EXP_WIDTH  = exp_bits(FP_FORMAT),
    localparam int unsigned MANT_WIDTH = man_bits(FP_FORMAT),
    localparam int unsigned URES_WIDTH = FP_WIDTH + 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [URES_WIDTH-1:0] urnd_result_i,
    input  logic [2:0]            rnd_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [FP_WIDTH-1:0]   result_o,
`ifdef FP_ROUND_FLAGS_ACC_EN
    input  logic                  flags_clr_i,
    output logic [4:0]            flags_acc_o,
`endif
    output logic [4:0]            fflags_o
);

    // Bit layout of the flat urnd_result_i bus, MSB first.
    typedef struct packed {
        logic [FP_WIDTH-1:0] u_result;
        logic [1:0]          rs;
        logic                round_en;
        logic                invalid;
        logic [1:0]          exp_cout;
    } uround_res_t;

    localparam int unsigned EM_WIDTH = EXP_WIDTH + MANT_WIDTH;
    localparam logic [EXP_WIDTH-1:0] C_EXP_ONES = '1;
    localparam logic [EM_WIDTH-1:0]  C_INF_EM   = {C_EXP_ONES, {MANT_WIDTH{1'b0}}};
    localparam logic [EM_WIDTH-1:0]  C_MAX_EM   = {{(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};

    logic                r_s1_v;
    uround_res_t         r_s1_res;
    roundmode_e          r_s1_rnd;
    logic                r_s2_v;
    logic [FP_WIDTH-1:0] r_result;
    logic [4:0]          r_fflags;

    logic                w_s2_ready;
    logic                w_s1_adv;
    logic                w_s1_load;
    logic                w_sign;
    logic                w_rnd_up;
    logic                w_sat_inf;
    logic                w_inc;
    logic [EM_WIDTH:0]   w_sum;
    logic                w_uf_wrap;
    logic                w_of;
    logic                w_nx;
    logic                w_uf;
    logic [FP_WIDTH-1:0] w_res;
    logic [4:0]          w_flags;

    // Handshake: ready_o sees ready_i through a single level only.
    assign w_s2_ready = ~r_s2_v | ready_i;
    assign w_s1_adv   = r_s1_v & w_s2_ready;
    assign ready_o    = ~r_s1_v | w_s2_ready;
    assign w_s1_load  = valid_i & ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_v   <= 1'b0;
            r_s1_res <= '0;
            r_s1_rnd <= RNE;
        end else begin
            if (ready_o) begin
                r_s1_v <= valid_i;
            end
            if (w_s1_load) begin
                r_s1_res <= uround_res_t'(urnd_result_i);
                r_s1_rnd <= roundmode_e'(rnd_i);
            end
        end
    end

    always_comb begin
        w_sign    = r_s1_res.u_result[FP_WIDTH-1];
        w_rnd_up  = 1'b0;
        w_sat_inf = 1'b1;
        case (r_s1_rnd)
            RNE: begin
                w_rnd_up  = r_s1_res.rs[1] & (r_s1_res.rs[0] | r_s1_res.u_result[0]);
                w_sat_inf = 1'b1;
            end
            RTZ: begin
                w_rnd_up  = 1'b0;
                w_sat_inf = 1'b0;
            end
            RDN: begin
                w_rnd_up  = w_sign & (|r_s1_res.rs);
                w_sat_inf = w_sign;
            end
            RUP: begin
                w_rnd_up  = ~w_sign & (|r_s1_res.rs);
                w_sat_inf = ~w_sign;
            end
            RMM: begin
                w_rnd_up  = r_s1_res.rs[1];
                w_sat_inf = 1'b1;
            end
            default: begin
                w_rnd_up  = 1'b0;
                w_sat_inf = 1'b1;
            end
        endcase
    end

    // Exponent and mantissa are incremented as one field so a mantissa carry bumps the exponent.
    always_comb begin
        w_inc     = r_s1_res.round_en & w_rnd_up;
        w_sum     = {1'b0, r_s1_res.u_result[EM_WIDTH-1:0]} + {{EM_WIDTH{1'b0}}, w_inc};
        w_uf_wrap = r_s1_res.round_en & (r_s1_res.exp_cout == 2'b11);
        w_of      = r_s1_res.round_en & ~w_uf_wrap
                  & ((r_s1_res.exp_cout == 2'b01) | w_sum[EM_WIDTH]
                     | (w_sum[EM_WIDTH-1 -: EXP_WIDTH] == C_EXP_ONES));

        if (!r_s1_res.round_en) begin
            w_res = r_s1_res.u_result;
        end else if (w_uf_wrap) begin
            w_res = {w_sign, {EM_WIDTH{1'b0}}};
        end else if (w_of) begin
            w_res = {w_sign, (w_sat_inf ? C_INF_EM : C_MAX_EM)};
        end else begin
            w_res = {w_sign, w_sum[EM_WIDTH-1:0]};
        end

        w_nx    = (r_s1_res.round_en & (|r_s1_res.rs)) | w_of | w_uf_wrap;
        w_uf    = w_nx & (w_res[FP_WIDTH-2 -: EXP_WIDTH] == '0);
        w_flags = {r_s1_res.invalid, 1'b0, w_of, w_uf, w_nx};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_v   <= 1'b0;
            r_result <= '0;
            r_fflags <= '0;
        end else begin
            if (w_s2_ready) begin
                r_s2_v <= r_s1_v;
            end
            if (w_s1_adv) begin
                r_result <= w_res;
                r_fflags <= w_flags;
            end
        end
    end

    assign valid_o  = r_s2_v;
    assign result_o = r_result;
    assign fflags_o = r_fflags;

`ifdef FP_ROUND_FLAGS_ACC_EN
    logic [4:0] r_flags_acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_flags_acc <= '0;
        end else if (flags_clr_i) begin
            r_flags_acc <= '0;
        end else if (r_s2_v & ready_i) begin
            r_flags_acc <= r_flags_acc | r_fflags;
        end
    end

    assign flags_acc_o = r_flags_acc;
`endif

endmodule

`default_nettype wire
